bcd_convert_scheduler: RTL and testbench

Shares a single iterative binary-to-BCD converter across all six calendar/time fields of the digital clock. On each refresh request it snapshots year, month, day, hour, minute and second, converts them one field at a time, and holds the resulting BCD digits stable for the LCD display list. It sits between the time/date counter and the display formatter, replacing one converter per field.

---
 rtl/bcd_convert_scheduler.sv | 104 ++++++++++
 tb/tb_bcd_convert_scheduler.sv | 134 +++++++++++++
 2 files changed

// File: rtl/bcd_convert_scheduler.sv
// bcd_convert_scheduler: one shared double-dabble converter time-multiplexed over six clock/date fields.
module bcd_convert_scheduler (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] second,
  input  logic [7:0] minute,
  input  logic [7:0] hour,
  input  logic [7:0] day,
  input  logic [7:0] month,
  input  logic [7:0] year,
  output logic       busy,
  output logic       done,
  output logic [3:0] ten_sec,
  output logic [3:0] one_sec,
  output logic [3:0] ten_min,
  output logic [3:0] one_min,
  output logic [3:0] ten_hour,
  output logic [3:0] one_hour,
  output logic [3:0] ten_day,
  output logic [3:0] one_day,
  output logic [3:0] ten_mon,
  output logic [3:0] one_mon,
  output logic [3:0] hun_year,
  output logic [3:0] ten_year,
  output logic [3:0] one_year
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STORE} state_t;
  state_t      r_state, w_next;
  logic [47:0] r_snap;
  logic [19:0] r_sr;
  logic [2:0]  r_idx;
  logic [2:0]  r_cnt;
  logic        r_pend;
  logic [7:0]  w_field;
  logic [19:0] w_adj;
  logic        w_go;
  assign busy    = r_state != IDLE;
  assign w_go    = start | r_pend;
  assign w_field = r_snap[{r_idx, 3'b000} +: 8];
  always_comb begin
    w_adj = {r_sr[19:16] >= 4'd5 ? r_sr[19:16] + 4'd3 : r_sr[19:16],
             r_sr[15:12] >= 4'd5 ? r_sr[15:12] + 4'd3 : r_sr[15:12],
             r_sr[11:8]  >= 4'd5 ? r_sr[11:8]  + 4'd3 : r_sr[11:8],
             r_sr[7:0]};
    w_next = r_state == IDLE  ? (w_go ? LOAD : IDLE) :
             r_state == LOAD  ? SHIFT :
             r_state == SHIFT ? (r_cnt == 3'd7 ? STORE : SHIFT) :
                                (r_idx == 3'd5 ? IDLE : LOAD);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snap   <= '0;
      r_sr     <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_pend   <= 1'b0;
      done     <= 1'b0;
      ten_sec  <= '0;
      one_sec  <= '0;
      ten_min  <= '0;
      one_min  <= '0;
      ten_hour <= '0;
      one_hour <= '0;
      ten_day  <= '0;
      one_day  <= '0;
      ten_mon  <= '0;
      one_mon  <= '0;
      hun_year <= '0;
      ten_year <= '0;
      one_year <= '0;
    end else begin
      // Starts arriving mid-pass, including on the final STORE, fold into one extra pass.
      r_pend <= r_state == IDLE ? 1'b0 : r_pend | start;
      done   <= r_state == STORE && r_idx == 3'd5;
      if (r_state == IDLE && w_go) begin
        r_snap <= {year, month, day, hour, minute, second};
        r_idx  <= '0;
      end
      if (r_state == LOAD) begin
        r_sr  <= {12'b0, w_field};
        r_cnt <= '0;
      end
      if (r_state == SHIFT) begin
        r_sr  <= {w_adj[18:0], 1'b0};
        r_cnt <= r_cnt + 3'd1;
      end
      if (r_state == STORE) begin
        r_idx <= r_idx + 3'd1;
        case (r_idx)
          3'd0:    {ten_sec, one_sec}             <= r_sr[15:8];
          3'd1:    {ten_min, one_min}             <= r_sr[15:8];
          3'd2:    {ten_hour, one_hour}           <= r_sr[15:8];
          3'd3:    {ten_day, one_day}             <= r_sr[15:8];
          3'd4:    {ten_mon, one_mon}             <= r_sr[15:8];
          default: {hun_year, ten_year, one_year} <= r_sr[19:8];
        endcase
      end
    end
  end
endmodule

// File: tb/tb_bcd_convert_scheduler.sv
// tb_bcd_convert_scheduler: randomized scoreboard bench with a pass-level timing and arithmetic model.
module tb_bcd_convert_scheduler;
  logic clk = 0, rst = 1, start = 0;
  logic [7:0] second = 0, minute = 0, hour = 0, day = 0, month = 0, year = 0;
  logic busy, done;
  logic [3:0] ten_sec, one_sec, ten_min, one_min, ten_hour, one_hour;
  logic [3:0] ten_day, one_day, ten_mon, one_mon, hun_year, ten_year, one_year;
  bcd_convert_scheduler dut (
    .clk(clk), .rst(rst), .start(start),
    .second(second), .minute(minute), .hour(hour), .day(day), .month(month), .year(year),
    .busy(busy), .done(done),
    .ten_sec(ten_sec), .one_sec(one_sec), .ten_min(ten_min), .one_min(one_min),
    .ten_hour(ten_hour), .one_hour(one_hour), .ten_day(ten_day), .one_day(one_day),
    .ten_mon(ten_mon), .one_mon(one_mon),
    .hun_year(hun_year), .ten_year(ten_year), .one_year(one_year)
  );
  always #5 clk = ~clk;
  typedef struct { logic [51:0] d; int c; } exp_t;
  exp_t q[$];
  int cyc = 0, checks = 0, errs = 0, m_s = 0;
  logic m_active = 0, m_pend = 0, m_done = 0, fin = 0, fin_done = 0;
  logic [51:0] m_disp = '0, m_full = '0;
  wire [51:0] w_dig = {ten_sec, one_sec, ten_min, one_min, ten_hour, one_hour,
                       ten_day, one_day, ten_mon, one_mon, hun_year, ten_year, one_year};
  function automatic logic [7:0] two(input logic [7:0] v);
    int x = int'(v) % 100;
    return {4'(x / 10), 4'(x % 10)};
  endfunction
  function automatic logic [11:0] three(input logic [7:0] v);
    int x = int'(v);
    return {4'(x / 100), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 0;
      m_pend   = 0;
      m_done   = 0;
      m_disp   = '0;
      q.delete();
      if (clk) cyc++;
    end else begin
      cyc++;
      m_done = 0;
      if (m_active) begin
        if (start) m_pend = 1;
        for (int k = 0; k < 6; k++)
          if (cyc == m_s + 10 * (k + 1)) begin
            if (k < 5) m_disp[51 - 8 * k -: 8] = m_full[51 - 8 * k -: 8];
            else m_disp[11:0] = m_full[11:0];
          end
        if (cyc == m_s + 60) begin
          m_active = 0;
          m_done   = 1;
        end
      end else if (start || m_pend) begin
        m_active = 1;
        m_pend   = 0;
        m_s      = cyc;
        m_full   = {two(second), two(minute), two(hour), two(day), two(month), three(year)};
        q.push_back('{m_full, cyc + 60});
      end
    end
  end
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h at cycle %0d", n, a, e, cyc);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    chk("digits", 64'(w_dig), 64'(m_disp));
    chk("busy", 64'(busy), 64'(m_active));
    chk("done", 64'(done), 64'(m_done));
    if (done === 1'b1) begin
      if (q.size() == 0) chk("done_unexpected", 64'(1), 64'(0));
      else begin
        e = q.pop_front();
        chk("pass_digits", 64'(w_dig), 64'(e.d));
        chk("done_cycle", 64'(cyc), 64'(e.c));
      end
    end
    if (fin && !fin_done) begin
      chk("queue_empty", 64'(q.size()), 64'(0));
      fin_done = 1;
    end
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse();
    start = 1;
    tick(1);
    start = 0;
  endtask
  task automatic set(input logic [7:0] s, mi, h, d, mo, y);
    second = s; minute = mi; hour = h; day = d; month = mo; year = y;
  endtask
  initial begin
    tick(3);
    rst = 0;
    tick(2);
    set(59, 59, 23, 31, 12, 123); pulse(); tick(70);
    set(12, 34, 5, 17, 8, 200);   pulse(); tick(70);
    set(59, 59, 1, 2, 3, 4);      pulse(); tick(5);
    second = 0; minute = 0;       tick(70);
    set(1, 2, 3, 4, 5, 6);        pulse(); tick(10);
    second = 7;                   pulse(); tick(5);
    pulse(); tick(20);
    pulse(); tick(140);
    set(45, 30, 11, 9, 6, 99);    pulse(); tick(24);
    #2 rst = 1;
    tick(2);
    rst = 0;
    tick(3);
    set(21, 43, 20, 28, 2, 77);   pulse(); tick(70);
    set(0, 0, 0, 0, 0, 0);        pulse(); tick(70);
    set(199, 99, 100, 255, 100, 255); pulse(); tick(70);
    for (int i = 0; i < 2500; i++) begin
      start = $urandom_range(0, 39) == 0;
      if ($urandom_range(0, 7) == 0)
        set(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      tick(1);
    end
    start = 0;
    tick(140);
    fin = 1;
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end
endmodule
